ss_map_sequencer: RTL and testbench
===================================

// Module: ss_map_sequencer
// PURPOSE
// - Parametrised N-map world selector for the sidescroller; successor to the fixed 3-ROM map mux.
// - Tracks the active map index from player LocX edge crossings: right edge = next map, left edge = previous map.
// - Supports optional wrap, a post-switch cooldown and a direct load from switches.
// - Registers the selected ROM port-A (game logic) and port-B (video) data. ROMs are instantiated outside, bus-packed in.
// PARAMETERS
// N_MAPS      3      number of map ROMs (>=2); IDX_W = $clog2(N_MAPS) localparam
// DATA_W      2      tile width per ROM port
// LOCX_W      8      width of LocX
// RIGHT_EDGE  8'h7C  LocX value that advances map
// LEFT_EDGE   8'h00  LocX value that retreats map (must differ from RIGHT_EDGE)
// START_MAP   0      map index after reset
// WRAP        1      1: last->0 and 0->last allowed; 0: bounded
// COOL_CYC    16     cycles edges are ignored after any switch (>=1)
// PORTS
// clk_75        in   1               75 MHz system clock
// reset         in   1               asynchronous, active-low
// LocX          in   LOCX_W          player X tile location
// map_load      in   1               1-cycle strobe: load map_load_idx
// map_load_idx  in   IDX_W           requested map (from debounced switches)
// map_rom_data  in   N_MAPS*DATA_W   port-A douta of each ROM, map k at [k*DATA_W +: DATA_W]
// map_rom_pixel in   N_MAPS*DATA_W   port-B doutb of each ROM, same packing
// worldmap_data out  DATA_W          selected port-A data, registered
// world_pixel   out  DATA_W          selected port-B data, registered
// map_idx       out  IDX_W           active map index
// map_changed   out  1               1-cycle pulse when map_idx changes
// at_bound      out  1               1-cycle pulse: edge hit with WRAP=0 at first/last map
// BEHAVIOUR
// - Reset (reset=0, async): map_idx=START_MAP, locx_prev=LocX reset value 0, FSM=IDLE, cool_cnt=0.
// - Reset also forces worldmap_data, world_pixel, map_changed and at_bound to 0.
// - Edge detect: locx_prev <= LocX every cycle.
// - Edge detect: rise_r = (LocX==RIGHT_EDGE && locx_prev!=RIGHT_EDGE); rise_l is the same with LEFT_EDGE.
// - Edge detect: a player parked on an edge triggers once only. LocX=0 right after reset does not trigger a left move.
// - FSM IDLE: priority is map_load > rise_r > rise_l.
// - IDLE, map_load with map_load_idx<N_MAPS: map_idx<=map_load_idx.
// - IDLE, map_load with map_load_idx>=N_MAPS: ignored. Loading the current index: no pulse, no cooldown.
// - IDLE, rise_r: idx<N_MAPS-1 -> idx+1. idx==N_MAPS-1 -> 0 if WRAP, else hold and pulse at_bound.
// - IDLE, rise_l: idx>0 -> idx-1. idx==0 -> N_MAPS-1 if WRAP, else hold and pulse at_bound.
// - Any actual index change: map_changed=1 next cycle, cool_cnt<=COOL_CYC-1, FSM->COOL.
// - FSM COOL: rise_r and rise_l are ignored, with no at_bound pulse. map_load is still honoured and restarts the cooldown.
// - COOL: cool_cnt decrements each cycle; at 0 the FSM goes to IDLE the following cycle.
// - Data path: worldmap_data <= map_rom_data[map_idx]; world_pixel <= map_rom_pixel[map_idx].
// - Data path latency: 1 clk from ROM dout to output.
// - Data path after a switch: output reflects the new map 1 clk after map_idx updates, plus the ROM read latency upstream.
// - No latches: every register holds its value when no condition fires.
// CONFIGURATION
// - MAP_BLANK_EN defined: world_pixel is forced to 0 while FSM==COOL, giving a blank transition frame.
// - MAP_BLANK_EN defined: worldmap_data is unaffected.
// - MAP_BLANK_EN undefined: world_pixel always passes the selected ROM pixel; the cooldown affects edge handling only.
// TESTING
// 1 Reset, N_MAPS=3, LocX=0, both ROM buses = {2'd3,2'd2,2'd1} -> map_idx=0, no map_changed, worldmap_data=1 after 1 clk.
// 2 LocX 0x7B->0x7C -> map_idx=1 next clk, map_changed pulse once. Hold 0x7C 40 clks -> no further change.
// 3 WRAP=1, idx=2, LocX rises to 0x7C -> idx=0. WRAP=0, same stimulus -> idx stays 2, at_bound pulse.
// 4 Switch occurs, then LocX 0x01->0x00 within COOL_CYC=16 clks -> ignored. Same step after 17 clks -> idx decrements.
// 5 map_load=1, map_load_idx=2 on the same clk as rise_r -> idx=2 (load wins). map_load_idx=3 -> ignored.
// 6 MAP_BLANK_EN defined: world_pixel=0 for 16 clks after a switch, then equals new map pixel. Undefined: never blanked.

Source files
------------

// File: rtl/ss_map_sequencer.sv
// ss_map_sequencer: N-map world selector stepping on LocX edge crossings with wrap, cooldown and direct load.
// Define MAP_BLANK_EN to blank world_pixel while the post-switch cooldown runs.
module ss_map_sequencer #(
    parameter int N_MAPS = 3,
    parameter int DATA_W = 2,
    parameter int LOCX_W = 8,
    parameter logic [LOCX_W-1:0] RIGHT_EDGE = 8'h7C,
    parameter logic [LOCX_W-1:0] LEFT_EDGE = 8'h00,
    parameter int START_MAP = 0,
    parameter bit WRAP = 1'b1,
    parameter int COOL_CYC = 16,
    localparam int IDX_W = $clog2(N_MAPS)
) (
    input  logic clk_75,
    input  logic reset,
    input  logic [LOCX_W-1:0] LocX,
    input  logic map_load,
    input  logic [IDX_W-1:0] map_load_idx,
    input  logic [N_MAPS*DATA_W-1:0] map_rom_data,
    input  logic [N_MAPS*DATA_W-1:0] map_rom_pixel,
    output logic [DATA_W-1:0] worldmap_data,
    output logic [DATA_W-1:0] world_pixel,
    output logic [IDX_W-1:0] map_idx,
    output logic map_changed,
    output logic at_bound
);
    localparam int CNT_W = COOL_CYC > 1 ? $clog2(COOL_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_MAPS - 1);
    localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOL_CYC - 1);
    typedef enum logic {IDLE, COOL} state_t;
    state_t state, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] cool_cnt, cool_nxt;
    logic [LOCX_W-1:0] locx_prev;
    logic rise_r, rise_l, load_ok, moving, bound_hit;
    logic [DATA_W-1:0] data_sel, pixel_sel;

    // Edges fire on arrival only, so a player parked on an edge moves once
    assign rise_r = LocX == RIGHT_EDGE && locx_prev != RIGHT_EDGE;
    assign rise_l = LocX == LEFT_EDGE && locx_prev != LEFT_EDGE;
    assign load_ok = map_load && int'(map_load_idx) < N_MAPS;

    always_ff @(posedge clk_75 or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        idx_nxt = map_idx;
        bound_hit = 1'b0;
        if (load_ok)
            idx_nxt = map_load_idx;
        else if (state == IDLE && rise_r) begin
            idx_nxt = map_idx != LAST ? map_idx + IDX_W'(1) : WRAP ? '0 : map_idx;
            bound_hit = map_idx == LAST && !WRAP;
        end else if (state == IDLE && rise_l) begin
            idx_nxt = map_idx != '0 ? map_idx - IDX_W'(1) : WRAP ? LAST : map_idx;
            bound_hit = map_idx == '0 && !WRAP;
        end
        moving = idx_nxt != map_idx;
        state_nxt = moving ? COOL : state == COOL && cool_cnt == '0 ? IDLE : state;
        cool_nxt = moving ? COOL_INIT : cool_cnt != '0 ? cool_cnt - CNT_W'(1) : cool_cnt;
    end

    always_comb begin
        data_sel = map_rom_data[map_idx*DATA_W +: DATA_W];
`ifdef MAP_BLANK_EN
        pixel_sel = state == COOL ? '0 : map_rom_pixel[map_idx*DATA_W +: DATA_W];
`else
        pixel_sel = map_rom_pixel[map_idx*DATA_W +: DATA_W];
`endif
    end

    always_ff @(posedge clk_75 or negedge reset)
        if (!reset) begin
            map_idx <= IDX_W'(START_MAP);
            cool_cnt <= '0;
            locx_prev <= '0;
            map_changed <= 1'b0;
            at_bound <= 1'b0;
            worldmap_data <= '0;
            world_pixel <= '0;
        end else begin
            map_idx <= idx_nxt;
            cool_cnt <= cool_nxt;
            locx_prev <= LocX;
            map_changed <= moving;
            at_bound <= bound_hit;
            worldmap_data <= data_sel;
            world_pixel <= pixel_sel;
        end
endmodule

// File: tb/tb_ss_map_sequencer.sv
// tb_ss_map_sequencer: directed table, hand sequences and random stimulus against a reference model,
// driving one wrapping and one bounded instance side by side.
module tb_ss_map_sequencer;
    logic clk_75 = 1'b0;
    logic reset = 1'b0;
    logic [7:0] LocX = 8'h00;
    logic map_load = 1'b0;
    logic [1:0] map_load_idx = 2'd0;
    logic [5:0] map_rom_data = {2'd3, 2'd2, 2'd1};
    logic [5:0] map_rom_pixel = {2'd3, 2'd2, 2'd1};
    logic [1:0] wd[2], wp[2], mi[2];
    logic mc[2], ab[2];

    always #5 clk_75 = ~clk_75;

    ss_map_sequencer dut_w (
        .clk_75(clk_75), .reset(reset), .LocX(LocX), .map_load(map_load), .map_load_idx(map_load_idx),
        .map_rom_data(map_rom_data), .map_rom_pixel(map_rom_pixel), .worldmap_data(wd[0]),
        .world_pixel(wp[0]), .map_idx(mi[0]), .map_changed(mc[0]), .at_bound(ab[0]));

    ss_map_sequencer #(.WRAP(1'b0)) dut_b (
        .clk_75(clk_75), .reset(reset), .LocX(LocX), .map_load(map_load), .map_load_idx(map_load_idx),
        .map_rom_data(map_rom_data), .map_rom_pixel(map_rom_pixel), .worldmap_data(wd[1]),
        .world_pixel(wp[1]), .map_idx(mi[1]), .map_changed(mc[1]), .at_bound(ab[1]));

    int checks = 0, errors = 0, cycle = 0;
    // Model: index per instance (0 wraps, 1 bounded) and the number of upcoming edges that are ignored
    int m_idx[2], m_cool[2], m_data[2], m_pix[2];
    bit m_chg[2], m_bnd[2];
    logic [7:0] m_prev;

    typedef struct {
        logic [7:0] locx;
        bit load;
        logic [1:0] lidx;
        int reps;
        int ew_idx;
        bit ew_chg;
        int eb_idx;
        bit eb_bnd;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_idx[w] = 0; m_cool[w] = 0; m_data[w] = 0; m_pix[w] = 0; m_chg[w] = 0; m_bnd[w] = 0;
        end
        m_prev = 8'h00;
    endtask

    task automatic model_edge(input int w);
        int ni;
        bit ign, rr, rl;
        m_data[w] = int'(map_rom_data[2*m_idx[w] +: 2]);
`ifdef MAP_BLANK_EN
        m_pix[w] = m_cool[w] > 0 ? 0 : int'(map_rom_pixel[2*m_idx[w] +: 2]);
`else
        m_pix[w] = int'(map_rom_pixel[2*m_idx[w] +: 2]);
`endif
        rr = LocX == 8'h7C && m_prev != 8'h7C;
        rl = LocX == 8'h00 && m_prev != 8'h00;
        ign = m_cool[w] > 0;
        ni = m_idx[w];
        m_bnd[w] = 0;
        if (map_load && map_load_idx < 3) ni = int'(map_load_idx);
        else if (!ign && rr) begin
            if (m_idx[w] < 2) ni = m_idx[w] + 1;
            else if (w == 0) ni = 0;
            else m_bnd[w] = 1;
        end else if (!ign && rl) begin
            if (m_idx[w] > 0) ni = m_idx[w] - 1;
            else if (w == 0) ni = 2;
            else m_bnd[w] = 1;
        end
        m_chg[w] = ni != m_idx[w];
        m_cool[w] = m_chg[w] ? 16 : (ign ? m_cool[w] - 1 : 0);
        m_idx[w] = ni;
    endtask

    task automatic cyc();
        @(posedge clk_75);
        model_edge(0);
        model_edge(1);
        m_prev = LocX;
        #1;
        cycle++;
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("c%0d u%0d map_idx", cycle, w), int'(mi[w]), m_idx[w]);
            chk($sformatf("c%0d u%0d map_changed", cycle, w), int'(mc[w]), int'(m_chg[w]));
            chk($sformatf("c%0d u%0d at_bound", cycle, w), int'(ab[w]), int'(m_bnd[w]));
            chk($sformatf("c%0d u%0d worldmap_data", cycle, w), int'(wd[w]), m_data[w]);
            chk($sformatf("c%0d u%0d world_pixel", cycle, w), int'(wp[w]), m_pix[w]);
        end
    endtask

    task automatic add(input logic [7:0] lx, input bit ld, input logic [1:0] li, input int reps,
                       input int ewi, input bit ewc, input int ebi, input bit ebb);
        vec_t v;
        v.locx = lx; v.load = ld; v.lidx = li; v.reps = reps;
        v.ew_idx = ewi; v.ew_chg = ewc; v.eb_idx = ebi; v.eb_bnd = ebb;
        tbl.push_back(v);
    endtask

    task automatic check_reset(input string tag);
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("%s u%0d map_idx", tag, w), int'(mi[w]), 0);
            chk($sformatf("%s u%0d map_changed", tag, w), int'(mc[w]), 0);
            chk($sformatf("%s u%0d at_bound", tag, w), int'(ab[w]), 0);
            chk($sformatf("%s u%0d worldmap_data", tag, w), int'(wd[w]), 0);
            chk($sformatf("%s u%0d world_pixel", tag, w), int'(wp[w]), 0);
        end
    endtask

    initial begin
        add(8'h00, 0, 2'd0, 1, 0, 0, 0, 0);
        add(8'h7B, 0, 2'd0, 1, 0, 0, 0, 0);
        add(8'h7C, 0, 2'd0, 1, 1, 1, 1, 0);
        add(8'h7C, 0, 2'd0, 40, 1, 0, 1, 0);
        add(8'h7B, 0, 2'd0, 1, 1, 0, 1, 0);
        add(8'h7C, 0, 2'd0, 1, 2, 1, 2, 0);
        add(8'h7B, 0, 2'd0, 20, 2, 0, 2, 0);
        add(8'h7C, 0, 2'd0, 1, 0, 1, 2, 1);
        add(8'h01, 0, 2'd0, 1, 0, 0, 2, 0);
        add(8'h00, 0, 2'd0, 1, 0, 0, 1, 0);
        add(8'h01, 0, 2'd0, 15, 0, 0, 1, 0);
        add(8'h00, 0, 2'd0, 1, 2, 1, 1, 0);
        add(8'h7B, 0, 2'd0, 20, 2, 0, 1, 0);
        add(8'h7B, 1, 2'd0, 1, 0, 1, 0, 0);
        add(8'h7B, 0, 2'd0, 20, 0, 0, 0, 0);
        add(8'h7C, 1, 2'd2, 1, 2, 1, 2, 0);
        add(8'h7B, 0, 2'd0, 20, 2, 0, 2, 0);
        add(8'h7B, 1, 2'd3, 1, 2, 0, 2, 0);
        add(8'h7B, 1, 2'd0, 1, 0, 1, 0, 0);
        add(8'h01, 0, 2'd0, 20, 0, 0, 0, 0);
        add(8'h00, 0, 2'd0, 1, 2, 1, 0, 1);

        model_reset();
        repeat (3) @(posedge clk_75);
        #1;
        check_reset("reset");
        @(negedge clk_75);
        reset = 1'b1;
        cyc();
        chk("first worldmap_data", int'(wd[0]), 1);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                LocX = tbl[i].locx;
                map_load = tbl[i].load;
                map_load_idx = tbl[i].lidx;
                cyc();
            end
            map_load = 1'b0;
            chk($sformatf("vec%0d wrap map_idx", i), int'(mi[0]), tbl[i].ew_idx);
            chk($sformatf("vec%0d wrap map_changed", i), int'(mc[0]), int'(tbl[i].ew_chg));
            chk($sformatf("vec%0d bounded map_idx", i), int'(mi[1]), tbl[i].eb_idx);
            chk($sformatf("vec%0d bounded at_bound", i), int'(ab[1]), int'(tbl[i].eb_bnd));
        end

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0: LocX = 8'h00;
                1: LocX = 8'h01;
                2: LocX = 8'h7B;
                3: LocX = 8'h7C;
                default: LocX = 8'($urandom);
            endcase
            map_load = $urandom_range(0, 15) == 0;
            map_load_idx = 2'($urandom);
            map_rom_data = 6'($urandom);
            map_rom_pixel = 6'($urandom);
            cyc();
        end

        map_load = 1'b0;
        LocX = 8'h00;
        reset = 1'b0;
        #2;
        check_reset("async reset");
        model_reset();
        @(negedge clk_75);
        reset = 1'b1;

        map_rom_data = {2'd3, 2'd2, 2'd1};
        map_rom_pixel = {2'd1, 2'd3, 2'd2};
        LocX = 8'h7B; cyc();
        LocX = 8'h7C; cyc();
        chk("cool first switch", int'(mi[0]), 1);
        repeat (15) begin LocX = 8'h01; cyc(); end
        LocX = 8'h00; cyc();
        chk("cool edge at 16 ignored", int'(mi[0]), 1);
        LocX = 8'h01; cyc();
        LocX = 8'h7C; cyc();
        chk("cool second switch", int'(mi[0]), 2);
        LocX = 8'h01; cyc();
`ifdef MAP_BLANK_EN
        chk("pixel after switch", int'(wp[0]), 0);
`else
        chk("pixel after switch", int'(wp[0]), 1);
`endif
        repeat (15) begin LocX = 8'h01; cyc(); end
        LocX = 8'h00; cyc();
        chk("cool edge at 17 taken", int'(mi[0]), 1);
        chk("cool edge at 17 pulse", int'(mc[0]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
